// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response port between the MEM stage and the memory.
// The stage is the master. Address, data and strobes stay stable while a request waits for grant.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_stage.sv
// RV64 memory-access pipeline stage: issues loads and stores on the data-memory port,
// stalls upstream while an access is outstanding, and loads the writeback latches.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_v,
  input  logic [31:0] mem_ir,
  input  logic [63:0] mem_npc,
  input  logic [63:0] mem_alu_result,
  input  logic [63:0] mem_rfd,
  input  logic [63:0] mem_csrfd,
  input  logic        mem_exc,
  input  logic [63:0] mem_cause,
  input  logic        wb_squash,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic [4:0]  mem_drid,
  output logic [63:0] mem_ir_old,
  output logic        wb_v,
  output logic [31:0] wb_ir,
  output logic [63:0] wb_npc,
  output logic [63:0] wb_alu_result,
  output logic [63:0] wb_mem_result,
  output logic [63:0] wb_csrfd,
  output logic        wb_cs,
  output logic [63:0] wb_cause
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------- decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] offset;
  logic [5:0] sh;
  logic       is_load, is_store, is_mem;
  logic       f3_legal, aligned, live;

  assign opcode   = mem_ir[6:0];
  assign funct3   = mem_ir[14:12];
  assign offset   = mem_alu_result[2:0];
  assign sh       = {offset, 3'b000};
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = mem_v && (is_load || is_store);
  assign f3_legal = is_load ? (funct3 != 3'b111) : (funct3[2] == 1'b0);

  always_comb begin
    aligned = 1'b1;
    case (funct3[1:0])
      2'd1:    aligned = (offset[0] == 1'b0);
      2'd2:    aligned = (offset[1:0] == 2'b00);
      2'd3:    aligned = (offset == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  assign live = is_mem && !mem_exc && !wb_squash && f3_legal && aligned;

  // ---------------------------------------------------------------- store lanes
  logic [3:0] n_bytes;
  logic [7:0] lane_strb;

  assign n_bytes = 4'd1 << funct3[1:0];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_strb[gi] = (4'(gi) >= {1'b0, offset}) &&
                             (4'(gi) <  ({1'b0, offset} + n_bytes));
    end
  endgenerate

  // ---------------------------------------------------------------- load extract
  logic [63:0] r_shift;
  logic [63:0] load_data;

  assign r_shift = dmem.rdata >> sh;

  always_comb begin
    load_data = r_shift;
    case (funct3)
      3'b000:  load_data = {{56{r_shift[7]}},  r_shift[7:0]};
      3'b001:  load_data = {{48{r_shift[15]}}, r_shift[15:0]};
      3'b010:  load_data = {{32{r_shift[31]}}, r_shift[31:0]};
      3'b100:  load_data = {56'd0, r_shift[7:0]};
      3'b101:  load_data = {48'd0, r_shift[15:0]};
      3'b110:  load_data = {32'd0, r_shift[31:0]};
      default: load_data = r_shift;
    endcase
  end

  // ---------------------------------------------------------------- exceptions
  logic        exc_flag;
  logic [63:0] exc_cause;

  always_comb begin
    exc_flag  = 1'b0;
    exc_cause = 64'd0;
    if (mem_exc) begin
      exc_flag  = 1'b1;
      exc_cause = mem_cause;
    end else if (is_mem && !f3_legal) begin
      exc_flag  = 1'b1;
      exc_cause = 64'd2;
    end else if (is_mem && !aligned) begin
      exc_flag  = 1'b1;
      exc_cause = is_store ? 64'd6 : 64'd4;
    end else if (state_reg == S_RESP && dmem.rvalid && dmem.err) begin
      exc_flag  = 1'b1;
      exc_cause = is_store ? 64'd7 : 64'd5;
    end
  end

  // ---------------------------------------------------------------- FSM
  logic req_comb;
  logic stall_comb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_comb   = 1'b0;
    stall_comb = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_comb   = live;
        stall_comb = live;
        if (live) begin
          state_next = dmem.gnt ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        stall_comb = 1'b1;
        if (wb_squash) begin
          state_next = S_IDLE;
        end else begin
          req_comb = 1'b1;
          if (dmem.gnt) begin
            state_next = S_RESP;
          end
        end
      end
      // Squash is ignored once granted: the response is consumed and retired.
      S_RESP: begin
        stall_comb = !dmem.rvalid;
        if (dmem.rvalid) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign dmem.req   = req_comb && !rst;
  assign dmem.we    = is_store;
  assign dmem.addr  = {mem_alu_result[63:3], 3'b000};
  assign dmem.wdata = mem_rfd << sh;
  assign dmem.wstrb = lane_strb;

  assign mem_stall  = stall_comb;
  assign mem_drid   = mem_v ? mem_ir[11:7] : 5'd0;
  assign mem_ir_old = mem_v ? {32'd0, mem_ir} : 64'd0;

  // ---------------------------------------------------------------- writeback latches
  logic        wb_v_next,  wb_v_reg;
  logic [31:0] wb_ir_next, wb_ir_reg;
  logic [63:0] wb_npc_next, wb_npc_reg;
  logic [63:0] wb_alu_next, wb_alu_reg;
  logic [63:0] wb_memr_next, wb_memr_reg;
  logic [63:0] wb_csrfd_next, wb_csrfd_reg;
  logic        wb_cs_next, wb_cs_reg;
  logic [63:0] wb_cause_next, wb_cause_reg;

  always_comb begin
    wb_v_next     = mem_v && !stall_comb && !(wb_squash && state_reg != S_RESP);
    wb_ir_next    = 32'd0;
    wb_npc_next   = 64'd0;
    wb_alu_next   = 64'd0;
    wb_memr_next  = 64'd0;
    wb_csrfd_next = 64'd0;
    wb_cs_next    = 1'b0;
    wb_cause_next = 64'd0;
    if (wb_v_next) begin
      wb_ir_next    = mem_ir;
      wb_npc_next   = mem_npc;
      wb_alu_next   = mem_alu_result;
      wb_csrfd_next = mem_csrfd;
      wb_cs_next    = exc_flag;
      wb_cause_next = exc_cause;
      // Only a load that actually completed a memory transaction produces data.
      if (is_load && state_reg == S_RESP && !exc_flag) begin
        wb_memr_next = load_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_v_reg     <= 1'b0;
      wb_ir_reg    <= 32'd0;
      wb_npc_reg   <= 64'd0;
      wb_alu_reg   <= 64'd0;
      wb_memr_reg  <= 64'd0;
      wb_csrfd_reg <= 64'd0;
      wb_cs_reg    <= 1'b0;
      wb_cause_reg <= 64'd0;
    end else begin
      wb_v_reg     <= wb_v_next;
      wb_ir_reg    <= wb_ir_next;
      wb_npc_reg   <= wb_npc_next;
      wb_alu_reg   <= wb_alu_next;
      wb_memr_reg  <= wb_memr_next;
      wb_csrfd_reg <= wb_csrfd_next;
      wb_cs_reg    <= wb_cs_next;
      wb_cause_reg <= wb_cause_next;
    end
  end

  assign wb_v          = wb_v_reg;
  assign wb_ir         = wb_ir_reg;
  assign wb_npc        = wb_npc_reg;
  assign wb_alu_result = wb_alu_reg;
  assign wb_mem_result = wb_memr_reg;
  assign wb_csrfd      = wb_csrfd_reg;
  assign wb_cs         = wb_cs_reg;
  assign wb_cause      = wb_cause_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores with delayed grant,
// exceptions, squash in REQ/RESP and reset mid-access.
module tb_mem_stage;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_v;
  logic [31:0] mem_ir;
  logic [63:0] mem_npc, mem_alu_result, mem_rfd, mem_csrfd;
  logic        mem_exc;
  logic [63:0] mem_cause;
  logic        wb_squash;
  logic        mem_stall;
  logic [4:0]  mem_drid;
  logic [63:0] mem_ir_old;
  logic        wb_v;
  logic [31:0] wb_ir;
  logic [63:0] wb_npc, wb_alu_result, wb_mem_result, wb_csrfd;
  logic        wb_cs;
  logic [63:0] wb_cause;

  int checks   = 0;
  int failures = 0;
  int stall_cycles;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .mem_v         (mem_v),
    .mem_ir        (mem_ir),
    .mem_npc       (mem_npc),
    .mem_alu_result(mem_alu_result),
    .mem_rfd       (mem_rfd),
    .mem_csrfd     (mem_csrfd),
    .mem_exc       (mem_exc),
    .mem_cause     (mem_cause),
    .wb_squash     (wb_squash),
    .dmem          (dmem),
    .mem_stall     (mem_stall),
    .mem_drid      (mem_drid),
    .mem_ir_old    (mem_ir_old),
    .wb_v          (wb_v),
    .wb_ir         (wb_ir),
    .wb_npc        (wb_npc),
    .wb_alu_result (wb_alu_result),
    .wb_mem_result (wb_mem_result),
    .wb_csrfd      (wb_csrfd),
    .wb_cs         (wb_cs),
    .wb_cause      (wb_cause)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {17'd0, f3, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(input logic v, input logic [31:0] ir, input logic [63:0] alu,
                       input logic [63:0] rfd);
    mem_v          = v;
    mem_ir         = ir;
    mem_alu_result = alu;
    mem_rfd        = rfd;
  endtask

  // Load with immediate grant and response on the following cycle.
  task automatic load_txn(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
    setop(1'b1, mk_ir(f3, 5'd6, OP_LOAD), addr, 64'd0);
    dmem.gnt = 1'b1;
    #1;
    chk({tag, "_req"}, dmem.req, 1);
    chk({tag, "_stall0"}, mem_stall, 1);
    cyc();
    chk({tag, "_bubble"}, wb_v, 0);
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = rdata;
    #1;
    chk({tag, "_stall1"}, mem_stall, 0);
    cyc();
    chk({tag, "_wb_v"}, wb_v, 1);
    chk({tag, "_result"}, wb_mem_result, exp);
    dmem.rvalid = 1'b0;
  endtask

  // Instruction that must except locally: no request, no stall, one-cycle retire.
  task automatic exc_txn(input string tag, input logic [31:0] ir, input logic [63:0] addr,
                         input logic exc_in, input logic [63:0] cause_in,
                         input logic [63:0] exp_cause);
    setop(1'b1, ir, addr, 64'd0);
    mem_exc   = exc_in;
    mem_cause = cause_in;
    #1;
    chk({tag, "_req"}, dmem.req, 0);
    chk({tag, "_stall"}, mem_stall, 0);
    cyc();
    chk({tag, "_cs"}, wb_cs, 1);
    chk({tag, "_cause"}, wb_cause, exp_cause);
    mem_exc   = 1'b0;
    mem_cause = 64'd0;
  endtask

  initial begin
    rst = 1'b1;
    setop(1'b0, 32'd0, 64'd0, 64'd0);
    mem_npc     = 64'h100;
    mem_csrfd   = 64'h55;
    mem_exc     = 1'b0;
    mem_cause   = 64'd0;
    wb_squash   = 1'b0;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 64'd0;
    dmem.err    = 1'b0;
    repeat (2) cyc();
    chk("rst_wb_v", wb_v, 0);
    chk("rst_req", dmem.req, 0);
    chk("rst_wb_ir", wb_ir, 0);
    rst = 1'b0;

    // ADD: single-cycle pass-through.
    setop(1'b1, mk_ir(3'd0, 5'd5, OP_ALU), 64'h1234, 64'd0);
    #1;
    chk("add_stall", mem_stall, 0);
    chk("add_req", dmem.req, 0);
    chk("add_drid", mem_drid, 5);
    chk("add_ir_old", mem_ir_old, 64'h2B3);
    cyc();
    chk("add_wb_v", wb_v, 1);
    chk("add_alu", wb_alu_result, 64'h1234);
    chk("add_ir", wb_ir, 64'h2B3);
    chk("add_npc", wb_npc, 64'h100);
    chk("add_csrfd", wb_csrfd, 64'h55);
    chk("add_memres", wb_mem_result, 0);
    chk("add_cs", wb_cs, 0);

    mem_v = 1'b0;
    #1;
    chk("bub_drid", mem_drid, 0);
    chk("bub_ir_old", mem_ir_old, 0);
    cyc();
    chk("bub_wb_v", wb_v, 0);
    chk("bub_alu", wb_alu_result, 0);

    // LB at 0x1003: address alignment and sign extension.
    setop(1'b1, mk_ir(3'b000, 5'd6, OP_LOAD), 64'h1003, 64'd0);
    #1;
    chk("lb_addr", dmem.addr, 64'h1000);
    chk("lb_we", dmem.we, 0);
    load_txn("lb",  3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load_txn("lbu", 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 64'h80);
    load_txn("lh",  3'b001, 64'h1002, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_8000);
    load_txn("lw",  3'b010, 64'h1004, 64'hF000_0001_0000_0000, 64'hFFFF_FFFF_F000_0001);
    load_txn("lwu", 3'b110, 64'h1004, 64'hF000_0001_0000_0000, 64'h0000_0000_F000_0001);
    load_txn("ld",  3'b011, 64'h1008, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);

    // SH at 0x2006 with grant delayed three cycles.
    setop(1'b1, mk_ir(3'b001, 5'd0, OP_STORE), 64'h2006, 64'hABCD);
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      dmem.gnt = (i == 3);
      #1;
      chk("sh_req", dmem.req, 1);
      chk("sh_we", dmem.we, 1);
      chk("sh_addr", dmem.addr, 64'h2000);
      chk("sh_wdata", dmem.wdata, 64'hABCD_0000_0000_0000);
      chk("sh_wstrb", dmem.wstrb, 64'hC0);
      if (mem_stall) stall_cycles++;
      cyc();
      chk("sh_bubble", wb_v, 0);
    end
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    #1;
    if (mem_stall) stall_cycles++;
    chk("sh_stall_cycles", stall_cycles, 4);
    cyc();
    chk("sh_wb_v", wb_v, 1);
    chk("sh_cs", wb_cs, 0);
    chk("sh_memres", wb_mem_result, 0);
    dmem.rvalid = 1'b0;

    // Local exceptions and upstream pass-through.
    exc_txn("lw_mis",  mk_ir(3'b010, 5'd1, OP_LOAD),  64'h3002, 1'b0, 64'd0,  64'd4);
    exc_txn("sd_mis",  mk_ir(3'b011, 5'd0, OP_STORE), 64'h3004, 1'b0, 64'd0,  64'd6);
    exc_txn("ld_ill",  mk_ir(3'b111, 5'd1, OP_LOAD),  64'h3000, 1'b0, 64'd0,  64'd2);
    exc_txn("st_ill",  mk_ir(3'b100, 5'd0, OP_STORE), 64'h3000, 1'b0, 64'd0,  64'd2);
    exc_txn("up_exc",  mk_ir(3'b010, 5'd1, OP_LOAD),  64'h3002, 1'b1, 64'hD, 64'hD);

    // Load returning an access fault.
    setop(1'b1, mk_ir(3'b011, 5'd2, OP_LOAD), 64'h4000, 64'd0);
    dmem.gnt = 1'b1;
    cyc();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.err    = 1'b1;
    cyc();
    chk("lerr_wb_v", wb_v, 1);
    chk("lerr_cs", wb_cs, 1);
    chk("lerr_cause", wb_cause, 64'd5);
    dmem.rvalid = 1'b0;
    dmem.err    = 1'b0;

    // Squash while waiting for grant: request withdrawn, nothing retires.
    setop(1'b1, mk_ir(3'b011, 5'd3, OP_LOAD), 64'h5000, 64'd0);
    cyc();
    wb_squash = 1'b1;
    #1;
    chk("sqreq_req", dmem.req, 0);
    cyc();
    chk("sqreq_wb_v", wb_v, 0);
    wb_squash = 1'b0;
    mem_v     = 1'b0;
    #1;
    chk("sqreq_idle_req", dmem.req, 0);
    cyc();

    // Squash while waiting for response: the load still retires.
    setop(1'b1, mk_ir(3'b011, 5'd3, OP_LOAD), 64'h6000, 64'd0);
    dmem.gnt = 1'b1;
    cyc();
    dmem.gnt    = 1'b0;
    wb_squash   = 1'b1;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("sqresp_stall", mem_stall, 0);
    cyc();
    chk("sqresp_wb_v", wb_v, 1);
    chk("sqresp_result", wb_mem_result, 64'h0123_4567_89AB_CDEF);
    wb_squash   = 1'b0;
    dmem.rvalid = 1'b0;

    // Reset during RESP, late response afterwards, then a clean ADD.
    setop(1'b1, mk_ir(3'b011, 5'd4, OP_LOAD), 64'h7000, 64'd0);
    dmem.gnt = 1'b1;
    cyc();
    dmem.gnt = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rstresp_req", dmem.req, 0);
    chk("rstresp_wb_v", wb_v, 0);
    cyc();
    rst         = 1'b0;
    mem_v       = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = 64'hDEAD_BEEF;
    #1;
    chk("late_stall", mem_stall, 0);
    chk("late_req", dmem.req, 0);
    cyc();
    chk("late_wb_v", wb_v, 0);
    chk("late_memres", wb_mem_result, 0);
    dmem.rvalid = 1'b0;
    setop(1'b1, mk_ir(3'd0, 5'd7, OP_ALU), 64'h99, 64'd0);
    #1;
    chk("post_add_stall", mem_stall, 0);
    cyc();
    chk("post_add_wb_v", wb_v, 1);
    chk("post_add_alu", wb_alu_result, 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RV64 core. It sits between execute and writeback: it consumes the MEM_* latches produced by execute, performs loads and stores over a request/grant/response data-memory port, and loads the WB_* latches that writeback consumes. It drives MEM_STALL to freeze upstream stages while an access is outstanding. It also exports MEM_DRID and MEM_IR_OLD to decode for hazard detection and forwarding.

## Interface
- No parameters; XLEN fixed at 64.
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-high reset
- MEM_V  in  1  instruction in MEM is valid
- MEM_IR  in  32  instruction
- MEM_NPC  in  64  next PC
- MEM_ALU_RESULT  in  64  ALU result; effective address for loads and stores
- MEM_RFD  in  64  rs2 value, used as store data
- MEM_CSRFD  in  64  CSR read data
- MEM_EXC  in  1  upstream exception already pending
- MEM_CAUSE  in  64  upstream exception cause
- WB_SQUASH  in  1  writeback redirect; kills the instruction in MEM
- DMEM_GNT  in  1  memory accepts the request
- DMEM_RVALID  in  1  response valid
- DMEM_RDATA  in  64  doubleword read data
- DMEM_ERR  in  1  access fault; qualified by DMEM_RVALID
- DMEM_REQ / DMEM_WE  out  1 / 1  request; write enable
- DMEM_ADDR  out  64  doubleword-aligned address {addr[63:3],3'b0}
- DMEM_WDATA / DMEM_WSTRB  out  64 / 8  lane-shifted store data; byte strobes
- MEM_STALL  out  1  combinational; upstream holds MEM_* while high
- MEM_DRID  out  5  MEM_IR[11:7] when MEM_V, else 0 (combinational)
- MEM_IR_OLD  out  64  {32'b0, MEM_IR} when MEM_V, else 0 (combinational)
- WB_V, WB_IR(32), WB_NPC(64), WB_ALU_RESULT(64), WB_MEM_RESULT(64), WB_CSRFD(64), WB_CS(1), WB_CAUSE(64)  out  writeback latches; WB_CS flags an exception

## Operation
- Decoding: a load is opcode 0000011 and a store is opcode 0100011; funct3 is IR[14:12]. Let a = MEM_ALU_RESULT and sh = 8*a[2:0].
- An access is **live** when all of these hold: MEM_V, the op is a load or store, !MEM_EXC, !WB_SQUASH, funct3 is legal, and the address is aligned to the access size.
- Exceptions and causes:
  - Illegal funct3 (load 111; store funct3 above 011): cause 2.
  - Misaligned load: cause 4. Misaligned store: cause 6.
  - DMEM_ERR on a load: cause 5. DMEM_ERR on a store: cause 7.
  - MEM_EXC passes MEM_CAUSE through unchanged, with priority over everything above.
  - No memory request is ever issued for an excepting instruction.
- Store path:
  - WDATA = MEM_RFD << sh.
  - WSTRB = (SB 0x01, SH 0x03, SW 0x0F, SD 0xFF) << a[2:0].
- Load path:
  - r = DMEM_RDATA >> sh.
  - LB/LH/LW sign-extend r[7:0], r[15:0], r[31:0]. LBU/LHU/LWU zero-extend them. LD uses r unchanged.
  - The result goes to WB_MEM_RESULT. Stores and non-memory ops write 0 there.
- FSM states:
  - IDLE: DMEM_REQ = live. If live && GNT, go to RESP. If live && !GNT, go to REQ.
  - REQ: DMEM_REQ = 1, with the address, data and strobes held stable. GNT moves to RESP. WB_SQUASH withdraws REQ in that cycle and moves to IDLE.
  - RESP: waiting for RVALID, which moves to IDLE. WB_SQUASH is ignored here; the access completes and the result is delivered.
- MEM_STALL = (live in IDLE) || state==REQ || (state==RESP && !DMEM_RVALID).
- WB latch update on every edge:
  - WB_V <= MEM_V && !MEM_STALL && !(WB_SQUASH && state!=RESP).
  - WB_IR, WB_NPC, WB_ALU_RESULT and WB_CSRFD copy their MEM_* inputs.
  - WB_CS and WB_CAUSE are the exception results above.
  - When WB_V is 0, every WB_* output is 0.
- RESET (asynchronous) sets: state IDLE; DMEM_REQ 0; every WB_* output 0.
- RESET asserted mid-access abandons the transaction. Any late RVALID arriving after reset is ignored.

## Timing
- Non-memory ops and excepting ops: one cycle; WB_* are valid on the edge after MEM_V.
- Memory ops: at least two cycles.
  - Cycle 0: REQ with GNT.
  - Cycle 1: RVALID; MEM_STALL drops and WB loads at the end of cycle 1.
- Each extra cycle without GNT or RVALID adds one cycle of stall.
- RVALID is never accepted in the same cycle as GNT.
- WB_V is 0 on every stalled cycle, so writeback sees bubbles during a stall.

## Test plan
- ADD with MEM_ALU_RESULT=0x1234, no memory op: WB_V=1 and WB_ALU_RESULT=0x1234 one cycle later; DMEM_REQ never asserted; MEM_STALL=0.
- LB at 0x1003, GNT immediate, RVALID next cycle with RDATA=0x00000000_80000000:
  - DMEM_ADDR=0x1000.
  - MEM_STALL high for exactly 1 cycle.
  - WB_MEM_RESULT=0xFFFFFFFF_FFFFFF80.
  - LBU on the same data gives 0x80.
- SH at 0x2006 with MEM_RFD=0xABCD, GNT delayed 3 cycles:
  - REQ, ADDR, WDATA=0xABCD<<48 and WSTRB=0xC0 held stable throughout.
  - MEM_STALL high for 4 cycles.
  - WB_V=1 with WB_CS=0 afterwards.
- LW at 0x3002: no request; WB_CS=1, WB_CAUSE=4, no stall. SD at 0x3004: WB_CAUSE=6. Load returning DMEM_ERR: WB_CAUSE=5.
- WB_SQUASH during REQ: REQ withdrawn and WB_V=0. WB_SQUASH during RESP: response consumed and the load retires normally.
- RESET asserted in RESP: DMEM_REQ and WB_V go to 0 immediately; a following RVALID is ignored; the next ADD completes in one cycle.
